// File: rtl/subtractor_128bit_seq.sv
// -----------------------------------------------------------------------------
// subtractor_128bit_seq
//
// Multi-cycle wide subtractor: oDiff = iA - iB - iBorrow (mod 2^DATA_WIDTH).
// The operation is split into N = DATA_WIDTH/CHUNK_WIDTH chunks, least
// significant first. Each RUN cycle adds one chunk of the minuend to the
// one's complement of the matching subtrahend chunk plus the rippled carry.
// The carry is the inverted borrow, so it starts as ~iBorrow, and the final
// borrow-out is the inverted carry of the top chunk.
//
// Ports
//   iClk     clock
//   iRstn    asynchronous active-low reset
//   iValid   operand request valid (taken only in IDLE)
//   oReady   block can accept operands (high only in IDLE)
//   iA       minuend,    DATA_WIDTH bits
//   iB       subtrahend, DATA_WIDTH bits
//   iBorrow  borrow-in
//   oValid   result valid (high only in DONE)
//   iReady   sink accepts result (observed only in DONE)
//   oDiff    difference, DATA_WIDTH bits, updated only on entry to DONE
//   oBorrow  borrow-out, 1 when iA < iB + iBorrow as unsigned values
// -----------------------------------------------------------------------------
module subtractor_128bit_seq #(
    parameter int DATA_WIDTH  = 128,
    parameter int CHUNK_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRstn,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [DATA_WIDTH-1:0] iA,
    input  logic [DATA_WIDTH-1:0] iB,
    input  logic                  iBorrow,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [DATA_WIDTH-1:0] oDiff,
    output logic                  oBorrow
);

    localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

    // Refuse to build a subtractor whose width is not a whole number of chunks.
    generate
        if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || DATA_WIDTH < CHUNK_WIDTH) begin : g_width_check
            $error("DATA_WIDTH must be a non-zero integer multiple of CHUNK_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [CNT_W-1:0]        cnt_q;
    logic                    carry_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [DATA_WIDTH-1:0]   res_q;
    logic [DATA_WIDTH-1:0]   res_d;
    logic [CHUNK_WIDTH:0]    chunk_sum;

    logic                    accept;
    logic                    last_chunk;

    assign accept     = (state_q == IDLE) && iValid;
    assign last_chunk = (cnt_q == LAST_CHUNK);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers sample pre-edge values and simulation matches the hardware.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: all outputs of this always_comb get a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        oReady  = 1'b0;
        oValid  = 1'b0;
        case (state_q)
            IDLE: begin
                oReady = 1'b1;
                if (iValid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                oValid = 1'b1;
                if (iReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Chunk arithmetic
    // -------------------------------------------------------------------------
    // The operand registers shift right by one chunk per RUN cycle, so the
    // chunk being processed always sits in the low CHUNK_WIDTH bits and no
    // wide selection mux is needed on the operand side.
    always_comb begin
        chunk_sum = {1'b0, a_q[CHUNK_WIDTH-1:0]}
                  + {1'b0, ~b_q[CHUNK_WIDTH-1:0]}
                  + {{CHUNK_WIDTH{1'b0}}, carry_q};
    end

    // Partial result with the current chunk merged in; becomes oDiff on the
    // last RUN cycle so the top chunk does not cost an extra cycle.
    always_comb begin
        res_d = res_q;
        res_d[int'(cnt_q) * CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum[CHUNK_WIDTH-1:0];
    end

    // -------------------------------------------------------------------------
    // Datapath storage without reset
    // -------------------------------------------------------------------------
    // NOTE: operand and partial-result registers are deliberately not reset:
    // they are always fully loaded or overwritten before being observed, and
    // leaving them out of the reset net keeps the wide datapath cheap.
    always_ff @(posedge iClk) begin
        if (accept) begin
            a_q <= iA;
            b_q <= iB;
        end else if (state_q == RUN) begin
            a_q   <= a_q >> CHUNK_WIDTH;
            b_q   <= b_q >> CHUNK_WIDTH;
            res_q <= res_d;
        end
    end

    // -------------------------------------------------------------------------
    // Control and result registers with reset
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            oDiff   <= '0;
            oBorrow <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                // Subtraction as addition of the one's complement: the carry-in
                // is the inverted borrow-in.
                carry_q <= ~iBorrow;
            end else if (state_q == RUN) begin
                carry_q <= chunk_sum[CHUNK_WIDTH];
                if (last_chunk) begin
                    cnt_q   <= '0;
                    oDiff   <= res_d;
                    oBorrow <= ~chunk_sum[CHUNK_WIDTH];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_subtractor_128bit_seq.sv
// -----------------------------------------------------------------------------
// tb_subtractor_128bit_seq
//
// Scoreboard bench for subtractor_128bit_seq. The driver pushes the expected
// difference/borrow (plain 129-bit arithmetic) and the accepting edge number
// when a request is taken; a separate monitor compares whenever oValid is
// high and pops on the result handshake.
// -----------------------------------------------------------------------------
module tb_subtractor_128bit_seq;

    localparam int DW = 128;
    localparam int CW = 32;
    localparam int N  = DW / CW;

    logic          iClk = 1'b0;
    logic          iRstn;
    logic          iValid;
    logic          oReady;
    logic [DW-1:0] iA;
    logic [DW-1:0] iB;
    logic          iBorrow;
    logic          oValid;
    logic          iReady;
    logic [DW-1:0] oDiff;
    logic          oBorrow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ready_mode = 2;   // 0: random stalls, 1: hold low, 2: hold high

    logic [DW-1:0] exp_diff_q[$];
    logic          exp_borrow_q[$];
    int            acc_edge_q[$];

    subtractor_128bit_seq #(
        .DATA_WIDTH (DW),
        .CHUNK_WIDTH(CW)
    ) dut (
        .iClk   (iClk),
        .iRstn  (iRstn),
        .iValid (iValid),
        .oReady (oReady),
        .iA     (iA),
        .iB     (iB),
        .iBorrow(iBorrow),
        .oValid (oValid),
        .iReady (iReady),
        .oDiff  (oDiff),
        .oBorrow(oBorrow)
    );

    always #5 iClk = ~iClk;

    // Edge counter: value seen between edges is the number of the last edge.
    initial forever begin
        @(posedge iClk);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [DW:0] ref_sub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic bin);
        // 129-bit difference: bit DW is set exactly when the true result is negative.
        return {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, bin};
    endfunction

    function automatic logic [DW-1:0] rand_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at posedge+2. Returns at posedge+2 after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bin);
        logic [DW:0] r;
        bit accepted;
        accepted = 0;
        iA = a;
        iB = b;
        iBorrow = bin;
        iValid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge iClk);
            if (oReady) begin
                r = ref_sub(a, b, bin);
                exp_diff_q.push_back(r[DW-1:0]);
                exp_borrow_q.push_back(r[DW]);
                acc_edge_q.push_back(cyc + 1);
                accepted = 1;
            end
            @(posedge iClk);
            #2;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got oReady=0 for 200 cycles required acceptance");
        end
        iValid  = 1'b0;
        iA      = rand_wide();
        iB      = rand_wide();
        iBorrow = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_diff_q.size() != 0; i++) @(negedge iClk);
        if (exp_diff_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results required 0", exp_diff_q.size());
        end
        @(posedge iClk);
        #2;
    endtask

    // Result sink back-pressure driver.
    initial begin
        iReady = 1'b0;
        forever begin
            @(posedge iClk);
            #2;
            case (ready_mode)
                0:       iReady = ($urandom_range(0, 3) != 0);
                1:       iReady = 1'b0;
                default: iReady = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        bit prev_valid;
        prev_valid = 0;
        forever begin
            @(negedge iClk);
            if (!iRstn) begin
                prev_valid = 0;
                continue;
            end
            if (oValid) begin
                if (exp_diff_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got oValid=1 with diff %h required no result", oDiff);
                end else begin
                    if (!prev_valid)
                        check("latency_edges", (DW+1)'(cyc - acc_edge_q[0] + 1), (DW+1)'(N + 1));
                    check("diff", {1'b0, oDiff}, {1'b0, exp_diff_q[0]});
                    check("borrow", (DW+1)'(oBorrow), (DW+1)'(exp_borrow_q[0]));
                    if (iReady) begin
                        void'(exp_diff_q.pop_front());
                        void'(exp_borrow_q.pop_front());
                        void'(acc_edge_q.pop_front());
                    end
                end
            end
            // A valid that survives a handshake must be a fresh result.
            prev_valid = oValid && !iReady;
        end
    end

    initial begin : stimulus
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW:0]   r;
        int            pat;
        bit            seen;

        iRstn = 1'b1;
        iValid = 1'b0;
        iA = '0;
        iB = '0;
        iBorrow = 1'b0;

        // Reset state
        #3 iRstn = 1'b0;
        #1;
        check("reset_ready",  (DW+1)'(oReady),  (DW+1)'(1));
        check("reset_valid",  (DW+1)'(oValid),  (DW+1)'(0));
        check("reset_diff",   {1'b0, oDiff},    '0);
        check("reset_borrow", (DW+1)'(oBorrow), (DW+1)'(0));
        repeat (2) @(negedge iClk);
        iRstn = 1'b1;
        @(posedge iClk);
        #2;

        // Directed cases
        ready_mode = 2;
        send(128'h5, 128'h3, 1'b0);
        send(128'h0, 128'h1, 1'b0);
        send(128'h1_00000000_00000000_00000000, 128'h1, 1'b0);
        send(128'h1_00000000_00000000_00000000, 128'h1, 1'b1);
        x = rand_wide();
        send(x, x, 1'b1);
        send(x, x, 1'b0);
        send({DW{1'b1}}, '0, 1'b1);
        drain();

        // Back-pressure with ignored iValid pulses during RUN
        ready_mode = 1;
        @(posedge iClk);
        #2;
        x = rand_wide();
        y = rand_wide();
        r = ref_sub(x, y, 1'b0);
        send(x, y, 1'b0);
        repeat (2) begin
            iValid = 1'b1;
            iA = rand_wide();
            @(posedge iClk);
            #2;
        end
        iValid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge iClk);
            seen = oValid;
        end
        check("stall_valid_reached", (DW+1)'(seen), (DW+1)'(1));
        repeat (10) begin
            @(negedge iClk);
            check("stall_valid", (DW+1)'(oValid), (DW+1)'(1));
            check("stall_diff",  {1'b0, oDiff},   {1'b0, r[DW-1:0]});
        end
        ready_mode = 2;
        @(posedge iClk);
        #3;
        @(posedge iClk);
        #1;
        check("handshake_ready", (DW+1)'(oReady), (DW+1)'(1));
        check("handshake_valid", (DW+1)'(oValid), (DW+1)'(0));
        #1;
        send(128'd10, 128'd20, 1'b0);
        drain();

        // Reset two cycles after accept: partial result dropped, no oValid
        x = rand_wide();
        send(x, rand_wide(), 1'b0);
        @(posedge iClk);
        #3;
        iRstn = 1'b0;
        #1;
        check("midrst_valid",  (DW+1)'(oValid),  (DW+1)'(0));
        check("midrst_ready",  (DW+1)'(oReady),  (DW+1)'(1));
        check("midrst_diff",   {1'b0, oDiff},    '0);
        check("midrst_borrow", (DW+1)'(oBorrow), (DW+1)'(0));
        exp_diff_q.delete();
        exp_borrow_q.delete();
        acc_edge_q.delete();
        @(negedge iClk);
        iRstn = 1'b1;
        @(posedge iClk);
        #2;
        send(128'h1234, 128'h0234, 1'b1);
        drain();

        // Random regression with random sink stalls
        ready_mode = 0;
        for (int n = 0; n < 2500; n++) begin
            pat = $urandom_range(0, 5);
            x = rand_wide();
            case (pat)
                0: y = rand_wide();
                1: y = x;
                2: begin x = '0; y = rand_wide(); end
                3: y = {DW{1'b1}};
                4: begin x = DW'($urandom_range(0, 15)); y = DW'($urandom_range(0, 15)); end
                default: y = x + DW'($urandom_range(0, 2)) - DW'(1);
            endcase
            send(x, y, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge iClk);
                #2;
            end
        end
        ready_mode = 2;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
